// File: rtl/motor_pwm_pkg.sv
// Shared types and helpers for the motor PWM generator: FSM states, default
// widths and the drive-magnitude saturation function.
package motor_pwm_pkg;

    localparam int unsigned DIN_W_DEF = 14;
    localparam int unsigned CNT_W_DEF = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_e;

    // Clamp an absolute drive value to the PWM period length.
    function automatic logic [31:0] sat_mag(input logic [31:0] abs_val,
                                            input logic [31:0] limit);
        return (abs_val > limit) ? limit : abs_val;
    endfunction

endpackage

// File: rtl/motor_pwm_gen_if.sv
// Drive-command / H-bridge bundle between the upstream filter and the PWM stage.
interface motor_pwm_gen_if
    import motor_pwm_pkg::*;
#(
    parameter int unsigned DIN_W = DIN_W_DEF
);
    logic             en;
    logic [DIN_W-1:0] din;
    logic             pwm;
    logic             dir;
    logic             coast;
    logic             sync;

    modport master (output en, din, input pwm, dir, coast, sync);
    modport slave  (input en, din, output pwm, dir, coast, sync);
endinterface

// File: rtl/motor_pwm_conv.sv
// Combinational two's-complement drive value to sign/magnitude, with the
// magnitude clamped to one PWM period.
module motor_pwm_conv
    import motor_pwm_pkg::*;
#(
    parameter int unsigned DIN_W  = DIN_W_DEF,
    parameter int unsigned PERIOD = 8191,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic [DIN_W-1:0] din,
    output logic [CNT_W-1:0] mag_c,
    output logic             sgn_c
);

    logic [DIN_W:0] din_ext;
    logic [DIN_W:0] abs_val;

    // One extra bit so the most negative input has a representable magnitude.
    always_comb begin
        din_ext = {din[DIN_W-1], din};
        abs_val = din[DIN_W-1] ? -din_ext : din_ext;
        mag_c   = CNT_W'(sat_mag(32'(abs_val), 32'(PERIOD)));
        sgn_c   = din[DIN_W-1];
    end

endmodule

// File: rtl/motor_pwm_gen.sv
// Fixed-frequency PWM generator with direction line, dead-time insertion on
// reversal and a per-period sync strobe.
module motor_pwm_gen
    import motor_pwm_pkg::*;
#(
    parameter int unsigned DIN_W    = DIN_W_DEF,
    parameter int unsigned PERIOD   = 8191,
    parameter int unsigned DEAD_CYC = 64,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input logic              clk,
    input logic              rst,
    motor_pwm_gen_if.slave   bus
);

    localparam logic [CNT_W-1:0] PER_END  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] mag_sh_q,   mag_sh_d;
    logic             dir_sh_q,   dir_sh_d;
    logic [CNT_W-1:0] pend_mag_q, pend_mag_d;
    logic             pend_sgn_q, pend_sgn_d;
    logic             pwm_q,      pwm_d;
    logic             coast_q,    coast_d;
    logic             sync_q,     sync_d;

    logic [CNT_W-1:0] mag_c;
    logic             sgn_c;

    motor_pwm_conv #(
        .DIN_W  (DIN_W),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_conv (
        .din   (bus.din),
        .mag_c (mag_c),
        .sgn_c (sgn_c)
    );

    // Outputs are registered against the next state, so pwm/coast/sync line
    // up with the state they describe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_sh_d   = mag_sh_q;
        dir_sh_d   = dir_sh_q;
        pend_mag_d = pend_mag_q;
        pend_sgn_d = pend_sgn_q;
        pwm_d      = 1'b0;
        coast_d    = 1'b0;
        sync_d     = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    mag_sh_d = mag_c;
                    dir_sh_d = sgn_c;
                    state_d  = RUN;
                    cnt_d    = '0;
                    sync_d   = 1'b1;
                end
                RUN: begin
                    pwm_d = (cnt_q < mag_sh_q);
                    if (cnt_q == PER_END) begin
                        cnt_d = '0;
                        // Reversal: hold the new command and coast first.
                        if ((mag_c != '0) && (sgn_c != dir_sh_q)) begin
                            state_d    = DEAD;
                            pend_mag_d = mag_c;
                            pend_sgn_d = sgn_c;
                            pwm_d      = 1'b0;
                            coast_d    = 1'b1;
                        end else begin
                            mag_sh_d = mag_c;
                            sync_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DEAD: begin
                    if (cnt_q == DEAD_END) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        mag_sh_d = pend_mag_q;
                        dir_sh_d = pend_sgn_q;
                        sync_d   = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        coast_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mag_sh_q   <= '0;
            dir_sh_q   <= 1'b0;
            pend_mag_q <= '0;
            pend_sgn_q <= 1'b0;
            pwm_q      <= 1'b0;
            coast_q    <= 1'b0;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_sh_q   <= mag_sh_d;
            dir_sh_q   <= dir_sh_d;
            pend_mag_q <= pend_mag_d;
            pend_sgn_q <= pend_sgn_d;
            pwm_q      <= pwm_d;
            coast_q    <= coast_d;
            sync_q     <= sync_d;
        end
    end

    assign bus.pwm   = pwm_q;
    assign bus.dir   = dir_sh_q;
    assign bus.coast = coast_q;
    assign bus.sync  = sync_q;

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Bench for motor_pwm_gen: directed scenarios plus random traffic, checked
// against a timeline model of periods, dead intervals and pulse windows.
module tb_motor_pwm_gen;

    localparam int DIN_W    = 14;
    localparam int PERIOD   = 16;
    localparam int DEAD_CYC = 4;
    localparam int CNT_W    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    motor_pwm_gen_if #(.DIN_W(DIN_W)) bus ();

    motor_pwm_gen #(
        .DIN_W    (DIN_W),
        .PERIOD   (PERIOD),
        .DEAD_CYC (DEAD_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle numbers for the current segment end and the
    // window of cycles in which the gate is expected high.
    int cyc     = 0;
    bit m_run   = 1'b0;
    bit m_dead  = 1'b0;
    bit m_dir   = 1'b0;
    int seg_end = 0;
    int hi_lo   = 0;
    int hi_hi   = -1;
    int p_mag   = 0;
    bit p_sgn   = 1'b0;
    bit exp_pwm = 1'b0, exp_dir = 1'b0, exp_coast = 1'b0, exp_sync = 1'b0;

    function automatic int sat_ref(input logic [DIN_W-1:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        return (v > PERIOD) ? PERIOD : v;
    endfunction

    function automatic void start_run(input int nc, input int m);
        m_run    = 1'b1;
        seg_end  = nc + PERIOD - 1;
        hi_lo    = nc + 1;
        hi_hi    = nc + m;
        exp_sync = 1'b1;
    endfunction

    function automatic void model_step();
        int nc;
        int m;
        bit s;
        nc       = cyc + 1;
        m        = sat_ref(bus.din);
        s        = ($signed(bus.din) < 0);
        exp_pwm  = m_run && (nc >= hi_lo) && (nc <= hi_hi);
        exp_sync = 1'b0;
        if (rst) begin
            m_run = 0; m_dead = 0; m_dir = 0; hi_lo = 0; hi_hi = -1; exp_pwm = 0;
        end else if (!bus.en) begin
            m_run = 0; m_dead = 0; hi_lo = 0; hi_hi = -1; exp_pwm = 0;
        end else if (!m_run && !m_dead) begin
            m_dir = s;
            start_run(nc, m);
        end else if (cyc == seg_end) begin
            if (m_dead) begin
                m_dead = 0;
                m_dir  = p_sgn;
                start_run(nc, p_mag);
            end else if (m != 0 && s != m_dir) begin
                m_run = 0; m_dead = 1; p_mag = m; p_sgn = s;
                seg_end = nc + DEAD_CYC - 1;
                hi_lo = 0; hi_hi = -1; exp_pwm = 0;
            end else begin
                start_run(nc, m);
            end
        end
        exp_coast = m_dead;
        exp_dir   = m_dir;
        cyc       = nc;
    endfunction

    function automatic logic [3:0] exp_vec();
        return {exp_pwm, exp_dir, exp_coast, exp_sync};
    endfunction

    function automatic logic [3:0] obs_vec();
        return {bus.pwm, bus.dir, bus.coast, bus.sync};
    endfunction

    // Advance one clock; outputs are then observed at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        int hi;
        rst = 1'b1; bus.en = 1'b1; bus.din = 14'd5;
        repeat (3) begin
            tick();
            if (obs_vec() !== 4'b0000) begin
                errors++; $display("FAIL reset_outputs got=%b exp=0000", obs_vec());
            end
            checks++;
        end
        rst = 1'b0;
        tick();
        if (bus.sync !== 1'b1) begin
            errors++; $display("FAIL reset_release_sync got=%b exp=1", bus.sync);
        end
        checks++;
        hi = int'(bus.pwm);
        repeat (2 * PERIOD - 1) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
            hi += int'(bus.pwm);
        end
        if (hi !== 10 || bus.dir !== 1'b0) begin
            errors++; $display("FAIL reset_duty high=%0d exp=10 dir=%b exp=0", hi, bus.dir);
        end
        checks++;
    endtask

    task automatic test_extremes();
        int hi, co;
        logic [DIN_W-1:0] vals [3];
        int exp_hi [3];
        vals[0] = 14'h1FFF; vals[1] = 14'h0000; vals[2] = 14'h2000;
        exp_hi[0] = 16; exp_hi[1] = 0; exp_hi[2] = 16;
        for (int k = 0; k < 3; k++) begin
            bus.din = vals[k];
            co = 0;
            repeat (4 * PERIOD) begin
                tick();
                if (obs_vec() !== exp_vec()) begin
                    errors++; $display("FAIL extreme_model k=%0d cyc=%0d got=%b exp=%b", k, cyc, obs_vec(), exp_vec());
                end
                checks++;
                co += int'(bus.coast);
            end
            hi = 0;
            repeat (PERIOD) begin
                tick();
                hi += int'(bus.pwm);
            end
            if (hi !== exp_hi[k] || co !== (k == 2 ? DEAD_CYC : 0) || bus.dir !== (k == 2)) begin
                errors++; $display("FAIL extreme_level k=%0d high=%0d exp=%0d coast=%0d dir=%b", k, hi, exp_hi[k], co, bus.dir);
            end
            checks++;
        end
    endtask

    task automatic test_mid_period();
        int hi1, hi2, guard;
        bus.din = 14'd4;
        repeat (3 * PERIOD) tick();
        guard = 0;
        do begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL mid_align cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
            guard++;
        end while (!exp_sync && guard < 40);
        if (bus.sync !== 1'b1) begin
            errors++; $display("FAIL mid_sync got=%b exp=1", bus.sync);
        end
        checks++;
        hi1 = int'(bus.pwm);
        repeat (7) begin tick(); hi1 += int'(bus.pwm); end
        bus.din = 14'd12;
        repeat (8) begin tick(); hi1 += int'(bus.pwm); end
        hi2 = 0;
        repeat (PERIOD) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL mid_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
            hi2 += int'(bus.pwm);
        end
        if (hi1 !== 4 || hi2 !== 12) begin
            errors++; $display("FAIL mid_duty first=%0d exp=4 second=%0d exp=12", hi1, hi2);
        end
        checks++;
    endtask

    task automatic test_reversal();
        int co, hi, guard;
        bus.din = 14'd8;
        repeat (3 * PERIOD) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rev_pre cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        bus.din = -14'sd3;
        co = 0; guard = 0;
        while (bus.dir !== 1'b1 && guard < 60) begin
            tick();
            if (bus.coast === 1'b1 && bus.pwm !== 1'b0) begin
                errors++; $display("FAIL rev_coast_pwm cyc=%0d pwm=%b exp=0", cyc, bus.pwm);
            end
            checks++;
            co += int'(bus.coast);
            guard++;
        end
        if (co !== DEAD_CYC || bus.sync !== 1'b1 || bus.pwm !== 1'b0 || bus.coast !== 1'b0) begin
            errors++; $display("FAIL rev_dead coast=%0d exp=%0d sync=%b pwm=%b coast_now=%b", co, DEAD_CYC, bus.sync, bus.pwm, bus.coast);
        end
        checks++;
        hi = int'(bus.pwm);
        repeat (PERIOD - 1) begin tick(); hi += int'(bus.pwm); end
        if (hi !== 3) begin
            errors++; $display("FAIL rev_duty high=%0d exp=3", hi);
        end
        checks++;
        bus.din = 14'd0;
        repeat (3 * PERIOD) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL rev_zero cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (bus.dir !== 1'b1 || bus.pwm !== 1'b0) begin
            errors++; $display("FAIL rev_zero_dir dir=%b exp=1 pwm=%b exp=0", bus.dir, bus.pwm);
        end
        checks++;
    endtask

    task automatic test_enable_drop();
        int hi, guard;
        bus.din = 14'd10;
        repeat (3 * PERIOD) tick();
        guard = 0;
        do begin tick(); guard++; end while (!exp_sync && guard < 40);
        repeat (2) tick();
        if (bus.pwm !== 1'b1) begin
            errors++; $display("FAIL drop_pre pwm=%b exp=1", bus.pwm);
        end
        checks++;
        bus.en = 1'b0;
        tick();
        if (bus.pwm !== 1'b0 || bus.coast !== 1'b0 || bus.sync !== 1'b0) begin
            errors++; $display("FAIL drop_off pwm=%b coast=%b sync=%b exp=000", bus.pwm, bus.coast, bus.sync);
        end
        checks++;
        repeat (3) begin
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drop_idle cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        bus.en = 1'b1;
        tick();
        if (bus.sync !== 1'b1) begin
            errors++; $display("FAIL drop_resync got=%b exp=1", bus.sync);
        end
        checks++;
        hi = int'(bus.pwm);
        repeat (PERIOD - 1) begin tick(); hi += int'(bus.pwm); end
        if (hi !== 10) begin
            errors++; $display("FAIL drop_duty high=%0d exp=10", hi);
        end
        checks++;
    endtask

    task automatic test_reset_dead();
        int guard;
        bus.din = -14'sd7;
        guard = 0;
        while (bus.coast !== 1'b1 && guard < 40) begin tick(); guard++; end
        tick();
        if (bus.coast !== 1'b1 || bus.dir !== 1'b0) begin
            errors++; $display("FAIL rdead_enter coast=%b exp=1 dir=%b exp=0", bus.coast, bus.dir);
        end
        checks++;
        rst = 1'b1;
        tick();
        if (obs_vec() !== 4'b0000) begin
            errors++; $display("FAIL rdead_reset got=%b exp=0000", obs_vec());
        end
        checks++;
        bus.din = 14'd2;
        rst = 1'b0;
        repeat (2 * PERIOD) begin
            tick();
            if (obs_vec() !== exp_vec() || bus.dir !== 1'b0 || bus.coast !== 1'b0) begin
                errors++; $display("FAIL rdead_after cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int v;
        repeat (2000) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: v = 8191;
                    1: v = -8192;
                    2: v = 0;
                    3: v = int'($urandom_range(1, 20));
                    4: v = -int'($urandom_range(1, 20));
                    default: v = int'($urandom);
                endcase
                bus.din = DIN_W'(v);
            end
            bus.en = ($urandom_range(0, 59) != 0);
            rst    = ($urandom_range(0, 399) == 0);
            tick();
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
            checks++;
        end
        rst = 1'b0;
        bus.en = 1'b1;
    endtask

    initial begin
        bus.en  = 1'b1;
        bus.din = 14'd5;
        test_reset();
        test_extremes();
        test_mid_period();
        test_reversal();
        test_enable_drop();
        test_reset_dead();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor_pwm_gen.md
# motor_pwm_gen

Downstream stage of the motor-command B-spline smoothing filter. It consumes the filter's 14-bit signed, smoothed drive value and turns it into a fixed-frequency PWM drive with a separate direction line for the motor H-bridge. Direction reversals are inserted with a dead interval. A per-period strobe is provided so upstream stages can align their updates to PWM periods.

## Interface
- `DIN_W`, 14: width of the signed drive input (two's complement).
- `PERIOD`, 8191: PWM period in `clk` cycles; must be ≥2 and ≤2^(DIN_W-1)-1.
- `DEAD_CYC`, 64: length of the coast interval on direction reversal, in cycles; must be ≥1.
- `CNT_W`, 13: counter width; must satisfy 2^CNT_W > max(PERIOD, DEAD_CYC).

Ports:
- `clk`  in  1: single system clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: drive enable; level-sensitive.
- `din`  in  DIN_W: signed drive command from the filter.
- `pwm`  out  1: registered PWM gate drive.
- `dir`  out  1: registered direction; 1 = reverse (negative `din`).
- `coast`  out  1: high while in DEAD.
- `sync`  out  1: one-cycle pulse at the start of every RUN period.

## Operation
- Conversion of `din` to sign/magnitude:
  - `mag` = |`din`|, saturated to `PERIOD`.
  - -2^(DIN_W-1) maps to `PERIOD`.
  - `sgn` = `din` MSB.
- Shadow registers `mag_sh` and `dir_sh` are loaded only at sample points. `din` is ignored between sample points.
- State IDLE:
  - Entered on reset. `cnt`=0, `pwm`=0.
  - If `en`=1, sample `din` and go to RUN with `cnt`=0.
  - `dir_sh` takes `sgn` on this first sample, with no dead interval.
- State RUN:
  - `cnt` counts 0..PERIOD-1.
  - Next `pwm` = (`cnt` < `mag_sh`).
  - At `cnt`=PERIOD-1, sample `din`:
    - If `mag`≠0 and `sgn`≠`dir_sh`: go to DEAD with `cnt`=0. The new `mag` and `sgn` are held pending.
    - Otherwise: load `mag_sh`, keep RUN, `cnt`=0.
    - A zero magnitude never changes direction.
- State DEAD:
  - `pwm`=0, `coast`=1.
  - `cnt` counts 0..DEAD_CYC-1.
  - At DEAD_CYC-1: load the pending values into `mag_sh`/`dir_sh` and go to RUN with `cnt`=0.
- `sync` = 1 for one cycle whenever the next state is RUN with `cnt`=0. This covers IDLE→RUN, RUN wrap, and DEAD→RUN.
- `en`=0 in any state: next state is IDLE, `pwm`=0, `coast`=0, `cnt`=0. `dir` keeps its value.
- `rst` overrides `en` and everything else.

## Timing
- Reset values:
  - `pwm`=0, `dir`=0, `coast`=0, `sync`=0.
  - State IDLE, `cnt`=0, `mag_sh`=0, `dir_sh`=0.
- All outputs are registered, and `dir` = `dir_sh`.
- Latency:
  - `pwm` rises the cycle after the `cnt`=0 cycle.
  - `pwm` is high for exactly `mag_sh` cycles per period: 0 gives constant low, `PERIOD` gives constant high.
- The `sync` pulse is coincident with the cycle in which `cnt` first reads 0 in RUN.
- Sample point: `din` is captured on the clock edge ending `cnt`=PERIOD-1. Upstream must hold `din` stable on that edge; `sync` can be used as the update strobe.
- A direction reversal costs `DEAD_CYC` cycles with `pwm`=0.
  - `dir` toggles on the same edge that leaves DEAD.
  - `pwm` can never be high in the cycle where `dir` changes.
- When `en` falls mid-period, `pwm` is 0 from the next cycle. No partial-period completion.

## Structure
- Package `motor_pwm_pkg` holds:
  - the state enum (IDLE, RUN, DEAD);
  - the default `DIN_W`/`CNT_W` constants;
  - the magnitude saturation helper function.
- Sub-module `motor_pwm_conv`: combinational `din` → (`mag`, `sgn`) with saturation to `PERIOD`. Unit-tested separately.
- Top: the FSM, `cnt`, the shadow/pending registers and the output registers.

## Test plan
All scenarios use PERIOD=16 and DEAD_CYC=4.

- **Reset/IDLE:** assert `rst` with `en`=1 for 3 cycles → all outputs 0. Release with `din`=5 → `sync` pulse, then `pwm` high for exactly 5 of every 16 cycles, `dir`=0.
- **Saturation and extremes:**
  - `din`=+8191 → `pwm` constantly high.
  - `din`=0 → `pwm` constantly low.
  - `din`=-8192 → `pwm` constantly high with `dir`=1 (one 4-cycle DEAD on entry from `dir`=0).
- **Mid-period change:** change `din` from 4 to 12 at `cnt`=7 → current period still has 4 high cycles, next period has 12.
- **Reversal:** `din`=+8 for 2 periods, then -3 → one DEAD of 4 cycles with `coast`=1 and `pwm`=0. `dir` rises on DEAD exit, then 3-cycle pulses.
  - Follow with `din`=0 → `dir` stays 1.
- **Enable drop:** deassert `en` at `cnt`=2 of a `din`=10 period → `pwm`=0 next cycle, IDLE.
  - Reassert → `sync` next cycle and a fresh full period.
- **Reset mid-DEAD:** assert `rst` at DEAD `cnt`=1 → all outputs at reset values next cycle; the pending direction is discarded.
